// File: rtl/ann_mlp_engine.sv
// ann_mlp_engine: two-layer perceptron inference engine.
// Weights live in a write-only register file. One multiply-accumulate runs
// per cycle, then one activation cycle per neuron. All hidden neurons are
// evaluated first, then all output neurons. The result is published in a
// final DONE cycle and held until the consumer takes it.
// Optional build macro: ANN_ARGMAX_EN adds the class_idx output, which is
// the index of the largest output activation.
module ann_mlp_engine #(
    parameter int N_IN  = 30,
    parameter int N_HID = 5,
    parameter int N_OUT = 3,
    parameter int DW    = 10,
    parameter int FRAC  = 6,
    localparam int NW   = N_HID * N_IN + N_OUT * N_HID,
    localparam int AW   = $clog2(NW)
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    output logic                  weight_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*DW-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT*DW-1:0]   out_data,
    output logic [N_HID*DW-1:0]   hid_data,
    output logic                  busy
`ifdef ANN_ARGMAX_EN
    ,
    output logic [$clog2(N_OUT)-1:0] class_idx
`endif
);

    localparam int FAN_MAX = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int NEU_MAX = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int ACC_W   = 2 * DW + $clog2(FAN_MAX);
    localparam int KW      = (FAN_MAX > 1) ? $clog2(FAN_MAX) : 1;
    localparam int NNW     = (NEU_MAX > 1) ? $clog2(NEU_MAX) : 1;

    localparam logic signed [ACC_W-1:0] X_HI = ACC_W'(2 ** (DW - 1) - 1);
    localparam logic signed [ACC_W-1:0] X_LO = ACC_W'(-(2 ** (DW - 1)));
    localparam logic [DW:0]             HALF = (DW + 1)'(2 ** (FRAC - 1));
    localparam logic [DW-1:0]           ONE  = DW'(2 ** FRAC);
    localparam logic [AW:0]             NW_L = (AW + 1)'(NW);

    typedef enum logic [2:0] {
        IDLE,
        HID_MAC,
        HID_ACT,
        OUT_MAC,
        OUT_ACT,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic signed [DW-1:0]    w_mem         [NW];
    logic signed [DW-1:0]    feat_reg      [N_IN];
    logic signed [DW-1:0]    hid_work_reg  [N_HID];
    logic signed [DW-1:0]    out_work_reg  [N_OUT];
    logic signed [DW-1:0]    hid_data_reg  [N_HID];
    logic signed [DW-1:0]    out_data_reg  [N_OUT];
    logic signed [ACC_W-1:0] acc_reg;
    logic [AW-1:0]           waddr_reg;
    logic [KW-1:0]           k_reg;
    logic [NNW-1:0]          n_reg;
    logic                    out_valid_reg;
    logic                    weight_err_reg;

    logic                    accept;
    logic                    wr_ok;
    logic                    mac_last;
    logic                    neu_last;
    logic                    publish;
    logic signed [DW-1:0]    mac_x;
    logic signed [DW-1:0]    mac_w;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] x_shift;
    logic signed [DW-1:0]    x_sat;
    logic signed [DW-1:0]    x_q;
    logic [DW:0]             y_sum;
    logic signed [DW-1:0]    act_val;

    assign in_ready   = (state_reg == IDLE) && !out_valid_reg;
    assign accept     = in_valid && in_ready;
    assign wr_ok      = wr_en && (state_reg == IDLE) && ({1'b0, wr_addr} < NW_L);
    assign publish    = (state_reg == DONE) && !out_valid_reg;
    assign busy       = (state_reg != IDLE);
    assign out_valid  = out_valid_reg;
    assign weight_err = weight_err_reg;

    // End-of-fan-in and end-of-layer flags for whichever layer is active
    always_comb begin
        mac_last = 1'b0;
        neu_last = 1'b0;
        if (state_reg == HID_MAC || state_reg == HID_ACT) begin
            mac_last = (k_reg == KW'(N_IN - 1));
            neu_last = (n_reg == NNW'(N_HID - 1));
        end else begin
            mac_last = (k_reg == KW'(N_HID - 1));
            neu_last = (n_reg == NNW'(N_OUT - 1));
        end
    end

    // State register; an abort via reset always lands in IDLE
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state: walk hidden neurons, then output neurons, then hold the result
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = HID_MAC;
            HID_MAC: if (mac_last) state_next = HID_ACT;
            HID_ACT: state_next = neu_last ? OUT_MAC : HID_MAC;
            OUT_MAC: if (mac_last) state_next = OUT_ACT;
            OUT_ACT: state_next = neu_last ? DONE : OUT_MAC;
            DONE:    if (out_valid_reg && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Weight register file: writes only while idle, cleared by reset
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int j = 0; j < NW; j++) w_mem[j] <= '0;
        end else if (wr_ok) begin
            w_mem[wr_addr] <= wr_data;
        end
    end

    // MAC operands: the features and the hidden results rotate so that element 0 is always current
    always_comb begin
        mac_x = (state_reg == HID_MAC) ? feat_reg[0] : hid_work_reg[0];
        mac_w = w_mem[waddr_reg];
        prod  = mac_x * mac_w;
    end

    // Activation: rescale, saturate, then a hard-sigmoid y = x/4 + 0.5 clamped to [0, 1]
    always_comb begin
        x_shift = acc_reg >>> FRAC;
        if (x_shift > X_HI)      x_sat = X_HI[DW-1:0];
        else if (x_shift < X_LO) x_sat = X_LO[DW-1:0];
        else                     x_sat = x_shift[DW-1:0];
        x_q   = x_sat >>> 2;
        y_sum = {x_q[DW-1], x_q} + HALF;
        if (y_sum[DW])                 act_val = '0;
        else if (y_sum[DW-1:0] > ONE)  act_val = ONE;
        else                           act_val = y_sum[DW-1:0];
    end

    // Sequencing: fan-in/neuron counters, weight pointer, accumulator, result handshake
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            k_reg          <= '0;
            n_reg          <= '0;
            waddr_reg      <= '0;
            acc_reg        <= '0;
            out_valid_reg  <= 1'b0;
            weight_err_reg <= 1'b0;
        end else begin
            weight_err_reg <= wr_en && !wr_ok;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        k_reg     <= '0;
                        n_reg     <= '0;
                        waddr_reg <= '0;
                        acc_reg   <= '0;
                    end
                end
                HID_MAC, OUT_MAC: begin
                    acc_reg   <= acc_reg + ACC_W'(prod);
                    waddr_reg <= (waddr_reg == AW'(NW - 1)) ? '0 : waddr_reg + AW'(1);
                    k_reg     <= mac_last ? '0 : k_reg + KW'(1);
                end
                HID_ACT, OUT_ACT: begin
                    acc_reg <= '0;
                    n_reg   <= neu_last ? '0 : n_reg + NNW'(1);
                end
                DONE: begin
                    if (!out_valid_reg)  out_valid_reg <= 1'b1;
                    else if (out_ready)  out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    genvar gi;

    // Feature store: loaded on accept, rotated once per hidden MAC cycle
    for (gi = 0; gi < N_IN; gi++) begin : g_feat
        always_ff @(posedge Clock or negedge Rst) begin
            if (!Rst)                       feat_reg[gi] <= '0;
            else if (accept)                feat_reg[gi] <= in_data[gi*DW +: DW];
            else if (state_reg == HID_MAC)  feat_reg[gi] <= feat_reg[(gi + 1) % N_IN];
        end
    end

    // Hidden results: shifted in at each hidden ACT, rotated during output MACs
    for (gi = 0; gi < N_HID; gi++) begin : g_hid
        always_ff @(posedge Clock or negedge Rst) begin
            if (!Rst)
                hid_work_reg[gi] <= '0;
            else if (state_reg == HID_ACT)
                hid_work_reg[gi] <= (gi == N_HID - 1) ? act_val : hid_work_reg[(gi + 1) % N_HID];
            else if (state_reg == OUT_MAC)
                hid_work_reg[gi] <= hid_work_reg[(gi + 1) % N_HID];
        end
        // Published copy stays frozen until the next completed run
        always_ff @(posedge Clock or negedge Rst) begin
            if (!Rst)         hid_data_reg[gi] <= '0;
            else if (publish) hid_data_reg[gi] <= hid_work_reg[gi];
        end
        assign hid_data[gi*DW +: DW] = hid_data_reg[gi];
    end

    // Output results: shifted in at each output ACT, published in DONE
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
        always_ff @(posedge Clock or negedge Rst) begin
            if (!Rst)
                out_work_reg[gi] <= '0;
            else if (state_reg == OUT_ACT)
                out_work_reg[gi] <= (gi == N_OUT - 1) ? act_val : out_work_reg[(gi + 1) % N_OUT];
        end
        // Published copy stays frozen until the next completed run
        always_ff @(posedge Clock or negedge Rst) begin
            if (!Rst)         out_data_reg[gi] <= '0;
            else if (publish) out_data_reg[gi] <= out_work_reg[gi];
        end
        assign out_data[gi*DW +: DW] = out_data_reg[gi];
    end

`ifdef ANN_ARGMAX_EN
    localparam int CW = $clog2(N_OUT);

    logic [CW-1:0]        best_idx;
    logic signed [DW-1:0] best_val;
    logic [CW-1:0]        class_idx_reg;

    // Argmax over the finished outputs; strict compare keeps the lowest index on ties
    always_comb begin
        best_idx = '0;
        best_val = out_work_reg[0];
        for (int j = 1; j < N_OUT; j++) begin
            if (out_work_reg[j] > best_val) begin
                best_val = out_work_reg[j];
                best_idx = CW'(j);
            end
        end
    end

    // Class index is published together with the activations
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst)         class_idx_reg <= '0;
        else if (publish) class_idx_reg <= best_idx;
    end

    assign class_idx = class_idx_reg;
`endif

endmodule

// File: tb/tb_ann_mlp_engine.sv
// tb_ann_mlp_engine: directed vectors with hand-computed results. Stimulus
// pushes expectations into a scoreboard, and a monitor checks each result
// when out_valid rises.
`timescale 1ns/1ps
module tb_ann_mlp_engine;
    localparam int N_IN  = 30;
    localparam int N_HID = 5;
    localparam int N_OUT = 3;
    localparam int DW    = 10;
    localparam int AW    = 8;
    localparam int XW    = N_IN * DW;
    localparam int OW    = N_OUT * DW;
    localparam int HW    = N_HID * DW;
    localparam int LAT   = 174;

    logic          Clock = 1'b0;
    logic          Rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          weight_err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic [HW-1:0] hid_data;
    logic          busy;
`ifdef ANN_ARGMAX_EN
    logic [1:0]    class_idx;
`endif

    ann_mlp_engine dut (
        .Clock      (Clock),
        .Rst        (Rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .weight_err (weight_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .hid_data   (hid_data),
        .busy       (busy)
`ifdef ANN_ARGMAX_EN
        ,
        .class_idx  (class_idx)
`endif
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] o;
        logic [HW-1:0] h;
        int            cls;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic ov_prev = 1'b0;
    int   hw[N_HID][N_IN];
    int   ow[N_OUT][N_HID];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [OW-1:0] pack_out(input int a, input int b, input int c);
        logic [OW-1:0] r;
        r = '0;
        r[0*DW +: DW] = DW'(a);
        r[1*DW +: DW] = DW'(b);
        r[2*DW +: DW] = DW'(c);
        return r;
    endfunction

    function automatic logic [HW-1:0] pack_hid(input int a, input int b, input int c, input int d, input int e);
        logic [HW-1:0] r;
        r = '0;
        r[0*DW +: DW] = DW'(a);
        r[1*DW +: DW] = DW'(b);
        r[2*DW +: DW] = DW'(c);
        r[3*DW +: DW] = DW'(d);
        r[4*DW +: DW] = DW'(e);
        return r;
    endfunction

    function automatic logic [XW-1:0] feat_all(input int v);
        logic [XW-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [XW-1:0] feat_pattern();
        logic [XW-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*DW +: DW] = DW'(((i * 37) % 200) - 100);
        return r;
    endfunction

    task automatic write_weight(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = DW'(data);
        @(posedge Clock);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic program_weights();
        for (int h = 0; h < N_HID; h++)
            for (int i = 0; i < N_IN; i++) write_weight(h * N_IN + i, hw[h][i]);
        for (int o = 0; o < N_OUT; o++)
            for (int h = 0; h < N_HID; h++) write_weight(N_HID * N_IN + o * N_HID + h, ow[o][h]);
    endtask

    task automatic set_hid_rows(input int c0, input int c1, input int c2, input int c3, input int c4);
        for (int i = 0; i < N_IN; i++) begin
            hw[0][i] = c0; hw[1][i] = c1; hw[2][i] = c2; hw[3][i] = c3; hw[4][i] = c4;
        end
    endtask

    task automatic set_out_rows(input int r0, input int r1, input int r2);
        for (int h = 0; h < N_HID; h++) begin
            ow[0][h] = r0; ow[1][h] = r1; ow[2][h] = r2;
        end
    endtask

    // Present a vector, wait for acceptance, optionally queue the expected result
    task automatic start_run(input logic [XW-1:0] x, input logic [OW-1:0] eo,
                             input logic [HW-1:0] eh, input int ecls, input bit expect_out);
        int   waited;
        exp_t e;
        waited   = 0;
        in_data  = x;
        in_valid = 1'b1;
        @(negedge Clock);
        while (!in_ready && waited < 500) begin
            @(negedge Clock);
            waited++;
        end
        if (!in_ready) begin
            fail("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge Clock);
        #1;
        in_valid = 1'b0;
        if (expect_out) begin
            e.o       = eo;
            e.h       = eh;
            e.cls     = ecls;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        @(negedge Clock);
        while ((busy || out_valid) && waited < 500) begin
            @(negedge Clock);
            waited++;
        end
        if (busy || out_valid) fail("idle_timeout");
        @(posedge Clock);
        #1;
    endtask

    // Monitor: every rising out_valid must match the oldest queued expectation
    initial begin
        exp_t e;
        int   n_res;
        n_res = 0;
        forever begin
            @(negedge Clock);
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got out_data=0x%0h, required no result", out_data);
                end else begin
                    e = sb.pop_front();
                    n_res++;
                    $display("result %0d: out_data=0x%0h hid_data=0x%0h latency=%0d",
                             n_res, out_data, hid_data, cyc - e.acc_cyc);
                    check("out_data", 64'(out_data), 64'(e.o));
                    check("hid_data", 64'(hid_data), 64'(e.h));
                    check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
`ifdef ANN_ARGMAX_EN
                    check("class_idx", 64'(class_idx), 64'(e.cls));
`endif
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] eo3;
        logic [HW-1:0] eh3;
        int            waited;
        eo3 = pack_out(41, 22, 43);
        eh3 = pack_hid(47, 17, 32, 39, 24);

        // Reset state
        repeat (3) @(posedge Clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_hid_data", 64'(hid_data), 64'(0));
        check("rst_weight_err", 64'(weight_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
`ifdef ANN_ARGMAX_EN
        check("rst_class_idx", 64'(class_idx), 64'(0));
`endif
        Rst = 1'b1;
        @(posedge Clock);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Zero weights: every activation is 0.5
        start_run(feat_pattern(), pack_out(32, 32, 32), pack_hid(32, 32, 32, 32, 32), 0, 1'b1);
        wait_idle();

        // All weights 1.0, inputs 1.0: hidden saturates, everything clamps to 1.0
        set_hid_rows(64, 64, 64, 64, 64);
        set_out_rows(64, 64, 64);
        program_weights();
        start_run(feat_all(64), pack_out(64, 64, 64), pack_hid(64, 64, 64, 64, 64), 0, 1'b1);
        wait_idle();

        // Mixed, unsaturated weights exercise floor rounding of negative values
        set_hid_rows(2, -2, 0, 1, -1);
        set_out_rows(16, -16, 0);
        ow[2][0] = 64;
        program_weights();
        start_run(feat_all(64), eo3, eh3, 2, 1'b1);
        wait_idle();

        // Write and in_valid during busy are rejected; the result is unchanged
        start_run(feat_all(64), eo3, eh3, 2, 1'b1);
        repeat (4) @(posedge Clock);
        #1;
        wr_en    = 1'b1;
        wr_addr  = AW'(150);
        wr_data  = DW'(200);
        in_data  = feat_all(0);
        in_valid = 1'b1;
        @(posedge Clock);
        #1;
        wr_en = 1'b0;
        check("busy_wr_err_pulse", 64'(weight_err), 64'(1));
        @(posedge Clock);
        #1;
        check("busy_wr_err_clear", 64'(weight_err), 64'(0));
        in_valid = 1'b0;
        wait_idle();

        // Back-pressure: result held for 20 cycles, concurrent in_valid ignored
        out_ready = 1'b0;
        start_run(feat_all(64), eo3, eh3, 2, 1'b1);
        waited = 0;
        @(negedge Clock);
        while (!out_valid && waited < 400) begin
            @(negedge Clock);
            waited++;
        end
        if (!out_valid) fail("hold_wait_valid");
        in_data  = feat_all(0);
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            check("hold_out_valid", 64'(out_valid), 64'(1));
            check("hold_out_data", 64'(out_data), 64'(eo3));
            check("hold_hid_data", 64'(hid_data), 64'(eh3));
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clock);
        #1;
        check("release_out_valid", 64'(out_valid), 64'(0));
        check("release_in_ready", 64'(in_ready), 64'(1));
        check("release_busy", 64'(busy), 64'(0));

        // Negative hidden weights: hidden clamps to 0, outputs fall back to 0.5
        set_hid_rows(-64, -64, -64, -64, -64);
        set_out_rows(64, -64, 37);
        program_weights();
        start_run(feat_all(64), pack_out(32, 32, 32), pack_hid(0, 0, 0, 0, 0), 0, 1'b1);
        wait_idle();

        // Out-of-range address while idle is rejected with a single pulse
        write_weight(165, 64);
        check("badaddr_err_pulse", 64'(weight_err), 64'(1));
        @(posedge Clock);
        #1;
        check("badaddr_err_clear", 64'(weight_err), 64'(0));
        start_run(feat_all(64), pack_out(32, 32, 32), pack_hid(0, 0, 0, 0, 0), 0, 1'b1);
        wait_idle();

        // Only output neuron 2 has weights: it wins the argmax
        set_hid_rows(0, 0, 0, 0, 0);
        set_out_rows(0, 0, 64);
        program_weights();
        start_run(feat_all(64), pack_out(32, 32, 64), pack_hid(32, 32, 32, 32, 32), 2, 1'b1);
        wait_idle();

        // Reset mid-computation: aborted, no result, weights cleared
        start_run(feat_all(64), '0, '0, 0, 1'b0);
        repeat (10) @(posedge Clock);
        #3;
        Rst = 1'b0;
        #2;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        @(posedge Clock);
        #2;
        Rst = 1'b1;
        @(posedge Clock);
        #1;
        check("abort_in_ready", 64'(in_ready), 64'(1));
        repeat (200) @(posedge Clock);
        #1;
        check("abort_no_result", 64'(out_valid), 64'(0));
        start_run(feat_pattern(), pack_out(32, 32, 32), pack_hid(32, 32, 32, 32, 32), 0, 1'b1);
        wait_idle();

        // Drain the scoreboard
        waited = 0;
        while (sb.size() != 0 && waited < 500) begin
            @(posedge Clock);
            waited++;
        end
        if (sb.size() != 0) fail("scoreboard_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
